// File: rtl/rr_packet_arbiter_param.sv
// Round-robin output-port arbiter: grants one input port per packet, drives the
// crossbar select and downstream write, and re-arbitrates with no idle cycle between packets.
module rr_packet_arbiter_param #(
  parameter int NUM_PORTS   = 5,
  parameter int PACKET_SIZE = 32,
  parameter int FLIT_SIZE   = 4,
  parameter int VAR_LEN     = 0,
  parameter int SEL_W       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] request,
  input  logic [NUM_PORTS-1:0] tail,
  input  logic                 destination_full,
  output logic [NUM_PORTS-1:0] grant_vec,
  output logic [SEL_W-1:0]     crossbar_control,
  output logic                 write_request,
  output logic                 last_flit,
  output logic                 busy
);
  localparam int FLIT_NUM = PACKET_SIZE / FLIT_SIZE;
  localparam int CW       = (FLIT_NUM > 2) ? $clog2(FLIT_NUM) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]     ptr_q, idx, nxt_idx, base;
  logic [CW-1:0]        cnt_q;
  logic                 any_req, found, tail_hit;

  // idx falls back to NUM_PORTS when nothing is granted, which is the idle select code
  always_comb begin
    idx = SEL_W'(NUM_PORTS);
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant_q[i]) idx = SEL_W'(i);
  end

  assign nxt_idx = (idx == SEL_W'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
  assign any_req = |request;
  assign base    = last_flit ? nxt_idx : ptr_q;

  // Two-pass scan: ports at or above base first, then wrap to the low ports
  always_comb begin
    grant_d = '0;
    found   = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++)
      if (!found && request[j] && j >= int'(base)) begin
        grant_d[j] = 1'b1;
        found      = 1'b1;
      end
    for (int j = 0; j < NUM_PORTS; j++)
      if (!found && request[j]) begin
        grant_d[j] = 1'b1;
        found      = 1'b1;
      end
  end

  assign busy             = (state_q == SEND);
  assign grant_vec        = grant_q;
  assign crossbar_control = idx;
  assign write_request    = busy & ~destination_full;
  assign tail_hit         = (VAR_LEN != 0) && |(tail & grant_q);
  assign last_flit        = write_request & ((cnt_q == CW'(FLIT_NUM - 1)) | tail_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          grant_q <= grant_d;
          state_q <= SEND;
        end
        SEND: begin
          if (last_flit) begin
            cnt_q <= '0;
            ptr_q <= nxt_idx;
            if (any_req) grant_q <= grant_d;
            else begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end else if (write_request) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_packet_arbiter_param.sv
// Directed bench: fixed-length instance plus a tail-mode instance sharing stimulus.
module tb_rr_packet_arbiter_param;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] request, tail;
  logic       dfull;

  logic [4:0] gv_f, gv_v;
  logic [2:0] cc_f, cc_v;
  logic       wr_f, wr_v, lf_f, lf_v, bs_f, bs_v;
  logic [10:0] obs_f, obs_v, exp;
  logic [4:0]  g;
  int errors = 0;
  int checks = 0;

  localparam logic [10:0] IDLE_O = {5'b0, 3'd5, 1'b0, 1'b0, 1'b0};

  assign obs_f = {gv_f, cc_f, wr_f, lf_f, bs_f};
  assign obs_v = {gv_v, cc_v, wr_v, lf_v, bs_v};

  rr_packet_arbiter_param #(.NUM_PORTS(5), .PACKET_SIZE(32), .FLIT_SIZE(4), .VAR_LEN(0), .SEL_W(3)) dut_f (
    .clk(clk), .reset(reset), .request(request), .tail(tail), .destination_full(dfull),
    .grant_vec(gv_f), .crossbar_control(cc_f), .write_request(wr_f), .last_flit(lf_f), .busy(bs_f));

  rr_packet_arbiter_param #(.NUM_PORTS(5), .PACKET_SIZE(32), .FLIT_SIZE(4), .VAR_LEN(1), .SEL_W(3)) dut_v (
    .clk(clk), .reset(reset), .request(request), .tail(tail), .destination_full(dfull),
    .grant_vec(gv_v), .crossbar_control(cc_v), .write_request(wr_v), .last_flit(lf_v), .busy(bs_v));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; request = '0; tail = '0; dfull = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; request = '0; tail = '0; dfull = 1'b0;
    #1;
    checks++;
    if (obs_f !== IDLE_O) begin errors++; $display("FAIL reset_f: got %h want %h", obs_f, IDLE_O); end
    checks++;
    if (obs_v !== IDLE_O) begin errors++; $display("FAIL reset_v: got %h want %h", obs_v, IDLE_O); end
    request = 5'b11111;
    tick();
    checks++;
    if (obs_f !== IDLE_O) begin errors++; $display("FAIL reset_held: got %h want %h", obs_f, IDLE_O); end
    request = '0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    request = 5'b00100;
    #1;
    checks++;
    if (obs_f !== IDLE_O) begin errors++; $display("FAIL basic_pre: got %h want %h", obs_f, IDLE_O); end
    tick();
    for (int k = 0; k < 8; k++) begin
      exp = {5'b00100, 3'd2, 1'b1, k == 7, 1'b1};
      checks++;
      if (obs_f !== exp) begin errors++; $display("FAIL basic flit %0d: got %h want %h", k, obs_f, exp); end
      if (k == 7) request = '0;
      tick();
    end
    checks++;
    if (obs_f !== IDLE_O) begin errors++; $display("FAIL basic_idle: got %h want %h", obs_f, IDLE_O); end
  endtask

  task automatic test_round_robin();
    do_reset();
    request = 5'b11111;
    tick();
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < 8; k++) begin
        g = 5'(1 << p);
        exp = {g, 3'(p), 1'b1, k == 7, 1'b1};
        checks++;
        if (obs_f !== exp) begin errors++; $display("FAIL rr port %0d flit %0d: got %h want %h", p, k, obs_f, exp); end
        tick();
      end
    exp = {5'b00001, 3'd0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs_f !== exp) begin errors++; $display("FAIL rr_wrap: got %h want %h", obs_f, exp); end
  endtask

  task automatic test_stall();
    do_reset();
    request = 5'b00100;
    tick();
    request = '0;
    for (int c = 0; c < 11; c++) begin
      dfull = (c >= 3 && c <= 5);
      #1;
      exp = {5'b00100, 3'd2, !dfull, c == 10, 1'b1};
      checks++;
      if (obs_f !== exp) begin errors++; $display("FAIL stall cycle %0d: got %h want %h", c, obs_f, exp); end
      tick();
    end
    dfull = 1'b0;
    #1;
    checks++;
    if (obs_f !== IDLE_O) begin errors++; $display("FAIL stall_idle: got %h want %h", obs_f, IDLE_O); end
  endtask

  task automatic test_tail();
    do_reset();
    request = 5'b01000;
    tick();
    tail = 5'b00001;  // tail on a non-granted port
    #1;
    exp = {5'b01000, 3'd3, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs_v !== exp) begin errors++; $display("FAIL tail_foreign: got %h want %h", obs_v, exp); end
    tick();
    dfull = 1'b1; tail = 5'b01000;
    #1;
    exp = {5'b01000, 3'd3, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs_v !== exp) begin errors++; $display("FAIL tail_stalled: got %h want %h", obs_v, exp); end
    tick();
    dfull = 1'b0; tail = '0;
    #1;
    exp = {5'b01000, 3'd3, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs_v !== exp) begin errors++; $display("FAIL tail_flit2: got %h want %h", obs_v, exp); end
    tick();
    tail = 5'b01000; request = 5'b01001;
    #1;
    exp = {5'b01000, 3'd3, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs_v !== exp) begin errors++; $display("FAIL tail_last: got %h want %h", obs_v, exp); end
    checks++;
    if (lf_f !== 1'b0) begin errors++; $display("FAIL tail_fixed_ignored: got %b want 0", lf_f); end
    tick();
    tail = '0; request = '0;
    #1;
    exp = {5'b00001, 3'd0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs_v !== exp) begin errors++; $display("FAIL tail_next: got %h want %h", obs_v, exp); end
  endtask

  task automatic test_hold();
    do_reset();
    request = 5'b00010;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k == 2) request = '0;
      if (k == 7) request = 5'b00010;
      #1;
      exp = {5'b00010, 3'd1, 1'b1, k == 7, 1'b1};
      checks++;
      if (obs_f !== exp) begin errors++; $display("FAIL hold flit %0d: got %h want %h", k, obs_f, exp); end
      tick();
    end
    exp = {5'b00010, 3'd1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs_f !== exp) begin errors++; $display("FAIL hold_regrant: got %h want %h", obs_f, exp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    request = 5'b00100;
    tick();
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (obs_f !== IDLE_O) begin errors++; $display("FAIL rstmid_async: got %h want %h", obs_f, IDLE_O); end
    request = 5'b00010;
    tick();
    checks++;
    if (obs_f !== IDLE_O) begin errors++; $display("FAIL rstmid_held: got %h want %h", obs_f, IDLE_O); end
    reset = 1'b1;
    tick();
    exp = {5'b00010, 3'd1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs_f !== exp) begin errors++; $display("FAIL rstmid_regrant: got %h want %h", obs_f, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_tail();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_packet_arbiter_param.md
Name: rr_packet_arbiter_param

Overview:
- Parametrised round-robin output-port arbiter for the NoC router, one instance per output port.
- Grants one input port at a time and holds the grant for a whole packet.
- Drives the crossbar select and the write request to the downstream buffer.
- Generalises port count and packet length, adds a tail-flit mode for variable-length packets, and re-arbitrates back-to-back with no idle cycle between packets.

Parameters:
- NUM_PORTS, 5, number of requesting input ports (>=2).
- PACKET_SIZE, 32, packet length in bits (fixed mode), or maximum packet length in bits (tail mode).
- FLIT_SIZE, 4, flit width in bits; FLIT_NUM = PACKET_SIZE/FLIT_SIZE (>=2).
- VAR_LEN, 0, 0 = fixed FLIT_NUM-flit packets; 1 = packet ends on tail flit or at FLIT_NUM flits, whichever comes first.
- SEL_W, 3, crossbar_control width; must satisfy 2^SEL_W > NUM_PORTS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- request  in  NUM_PORTS  per-port packet request (level).
- tail  in  NUM_PORTS  per-port tail-flit flag, valid with the current flit; ignored when VAR_LEN=0.
- destination_full  in  1  downstream buffer full; stalls transfer.
- grant_vec  out  NUM_PORTS  one-hot grant to the input ports; 0 when idle.
- crossbar_control  out  SEL_W  binary index of the granted port; NUM_PORTS when none granted.
- write_request  out  1  flit transfer this cycle.
- last_flit  out  1  current transfer is the final flit of the packet.
- busy  out  1  a packet is in progress.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; grant_reg = 0; pointer = 0; counter = 0.
  - Outputs: grant_vec=0, crossbar_control=NUM_PORTS, write_request=0, last_flit=0, busy=0.
  - Applies mid-packet: the packet is abandoned and no flit is written after reset asserts.
- Arbitration (combinational):
  - base = (last_flit ? granted_idx+1 mod NUM_PORTS : pointer).
  - Grant the first requesting port scanning base, base+1, … with wrap-around. No request gives a grant of 0.
- States:
  - IDLE: outputs as in reset. If any request is set, load the arbitration result into grant_reg and go to SEND.
  - SEND: grant_vec = grant_reg; crossbar_control = index of grant_reg; busy = 1.
- Transfer rule:
  - write_request = SEND & ~destination_full.
  - counter increments on each write_request; it holds while destination_full=1.
- Last flit:
  - last_flit = write_request & (counter==FLIT_NUM-1 | (VAR_LEN & tail[granted_idx])).
  - On last_flit: counter <= 0; pointer <= granted_idx+1 mod NUM_PORTS.
  - If any request is set (the just-served port included, now lowest priority), load the new arbitration result into grant_reg and stay in SEND, giving zero bubble.
  - Otherwise grant_reg <= 0 and go to IDLE.
- Latency:
  - request rising in IDLE at edge t gives grant_vec and write_request (if not full) from cycle t+1.
  - Last flit at cycle t gives the new grant at cycle t+1.
- Atomicity:
  - Deasserting request mid-packet does not drop the grant; the packet runs to completion.
  - tail from non-granted ports is ignored.
  - tail is ignored while destination_full=1.
- Counter width: max(1, clog2(FLIT_NUM)); it never exceeds FLIT_NUM-1.
- Invariants:
  - grant_vec is one-hot or zero at all times.
  - crossbar_control always matches grant_vec.
  - Exactly one last_flit per granted packet.

Test Plan:
- Reset then request=5'b00100 held, full=0, NUM_PORTS=5, FLIT_NUM=8, VAR_LEN=0 -> crossbar_control=2 from the cycle after the request; 8 write_request cycles; last_flit on the 8th; busy falls the next cycle if request is cleared.
- request=5'b11111 held for 5 packets -> grant order 0,1,2,3,4; each packet is 8 write_request cycles; no idle cycle between packets; pointer wraps to 0 after port 4.
- destination_full=1 for 3 cycles during flit 4 -> write_request=0 for those 3 cycles; grant and counter held; the packet still ends after exactly 8 transfers (11 SEND cycles).
- VAR_LEN=1, port 3 asserts tail on its 3rd flit -> last_flit on the 3rd transfer; with request=5'b01001 the next grant goes to port 0.
- Port 1 granted, request[1] dropped after flit 2 -> grant held to flit 8; request[1] re-asserted alone at the last flit -> port 1 re-granted immediately.
- Assert reset during flit 5 -> all outputs 0 (crossbar_control=5) asynchronously; after release with request=5'b00010, arbitration restarts with pointer=0 and grants port 1.
